mux8_sel: RTL and testbench

8-to-1 single-bit selector with a combinational output and an optional registered output copy. It picks one bit of an 8-bit input vector using a 3-bit index. It is a leaf datapath primitive used wherever one lane out of eight must be steered onto a single wire. The registered copy gives downstream logic a timing-clean version of the selection.

---
 rtl/mux8_sel.sv | 53 +++++
 tb/tb_mux8_sel.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mux8_sel.sv
// mux8_sel: 8-to-1 single-bit selector with a combinational output and an optional
// registered copy (out_q/sel_q), enabled by defining MUX_OUT_REG_EN.
module mux8_sel #(
   parameter int unsigned N_IN  = 8,
   parameter int unsigned SEL_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_IN-1:0]   in,
   input  logic [SEL_W-1:0]  sel,
   input  logic              en,
   output logic              out,
   output logic              out_q,
   output logic [SEL_W-1:0]  sel_q
);

   // Steer one lane onto out; every sel code is a valid lane.
   always_comb begin
      out = 1'b0;
      case (sel)
         3'd0:    out = in[0];
         3'd1:    out = in[1];
         3'd2:    out = in[2];
         3'd3:    out = in[3];
         3'd4:    out = in[4];
         3'd5:    out = in[5];
         3'd6:    out = in[6];
         3'd7:    out = in[7];
         default: out = 1'b0;
      endcase
   end

`ifdef MUX_OUT_REG_EN
   // Timing-clean copy of the selection; reset wins over en.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q <= 1'b0;
         sel_q <= SEL_W'(0);
      end else if (en) begin
         out_q <= out;
         sel_q <= sel;
      end
   end
`else
   // Flop-free build: the "registered" outputs alias the live selection.
   assign out_q = out;
   assign sel_q = sel;

   logic unused_ctrl;
   assign unused_ctrl = &{1'b0, clk, rst_n, en};
`endif

endmodule

// File: tb/tb_mux8_sel.sv
// Directed bench for mux8_sel; expectations follow the build selected by MUX_OUT_REG_EN.
module tb_mux8_sel;

`ifdef MUX_OUT_REG_EN
   localparam bit REG_BUILD = 1'b1;
`else
   localparam bit REG_BUILD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in;
   logic [2:0] sel;
   logic       en;
   logic       out;
   logic       out_q;
   logic [2:0] sel_q;

   int vec_cnt = 0;
   int err_cnt = 0;

   mux8_sel dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .sel   (sel),
      .en    (en),
      .out   (out),
      .out_q (out_q),
      .sel_q (sel_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pick expected registered value for the reg build, or the live value otherwise.
   function automatic logic [7:0] pick(input logic [7:0] reg_v, input logic [7:0] comb_v);
      return REG_BUILD ? reg_v : comb_v;
   endfunction

   initial begin
      rst_n = 1'b0; in = 8'h00; sel = 3'd0; en = 1'b0;
      tick();
      check("rst_out",   8'(out),   8'd0);
      check("rst_out_q", 8'(out_q), 8'd0);
      check("rst_sel_q", 8'(sel_q), 8'd0);

      // Capture path: out immediate, out_q one enabled edge later.
      rst_n = 1'b1; in = 8'b1000_1010; sel = 3'd1; en = 1'b1;
      #1;
      check("sel1_out",      8'(out),   8'd1);
      check("sel1_out_q_pre", 8'(out_q), pick(8'd0, 8'd1));
      check("sel1_sel_q_pre", 8'(sel_q), pick(8'd0, 8'd1));
      tick();
      check("sel1_out_q", 8'(out_q), 8'd1);
      check("sel1_sel_q", 8'(sel_q), 8'd1);

      in = 8'b1000_0000; sel = 3'd7; #1;
      check("msb_out", 8'(out), 8'd1);
      sel = 3'd6; #1;
      check("sel6_out", 8'(out), 8'd0);
      in = 8'b1001_0000; sel = 3'd0; #1;
      check("lsb_out", 8'(out), 8'd0);
      sel = 3'd4; #1;
      check("sel4_out", 8'(out), 8'd1);
      tick();
      check("sel4_out_q", 8'(out_q), 8'd1);
      check("sel4_sel_q", 8'(sel_q), 8'd4);

      // Walking one and walking zero across every sel code.
      for (int i = 0; i < 8; i++) begin
         for (int s = 0; s < 8; s++) begin
            in = 8'(1 << i); sel = 3'(s); #1;
            check($sformatf("walk1_i%0d_s%0d", i, s), 8'(out), 8'(s == i));
            in = ~8'(1 << i); #1;
            check($sformatf("walk0_i%0d_s%0d", i, s), 8'(out), 8'(s != i));
         end
      end

      // Hold with en low.
      in = 8'b0000_0010; sel = 3'd1; en = 1'b1;
      tick();
      check("cap_out_q", 8'(out_q), 8'd1);
      en = 1'b0; in = 8'h00; sel = 3'd5;
      tick();
      tick();
      check("hold_out",   8'(out),   8'd0);
      check("hold_out_q", 8'(out_q), pick(8'd1, 8'd0));
      check("hold_sel_q", 8'(sel_q), pick(8'd1, 8'd5));

      // Reset beats en; out keeps tracking during reset.
      rst_n = 1'b0; en = 1'b1; in = 8'hFF; sel = 3'd3;
      tick();
      check("rstmid_out",   8'(out),   8'd1);
      check("rstmid_out_q", 8'(out_q), pick(8'd0, 8'd1));
      check("rstmid_sel_q", 8'(sel_q), pick(8'd0, 8'd3));
      in = 8'hF7; #1;
      check("rstmid_track", 8'(out), 8'd0);
      in = 8'hFF;
      rst_n = 1'b1;
      tick();
      check("post_rst_out_q", 8'(out_q), 8'd1);
      check("post_rst_sel_q", 8'(sel_q), 8'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
